// File: rtl/seq_detect_pkg.sv
// Shared encodings and defaults for the word-level sequence detector.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    REPORT = 2'b10
  } state_e;

  localparam int unsigned WORD_W_DEF = 16;

  // Reset pattern; the controller keeps the low PAT_W bits.
  localparam logic [31:0] DEF_PATTERN = 32'b0110;

  // Reported first-match index when a word contains no match.
  function automatic int unsigned none_idx(input int unsigned word_w);
    return word_w;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Serial Mealy pattern matcher: history shift register plus a saturating fill count.
module seq_match_core #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             match
);

  localparam int unsigned FW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FW-1:0] FULL = FW'(PAT_W - 1);

  logic [PAT_W-2:0] hist_q;
  logic [FW-1:0]    fill_q;
  logic [PAT_W-1:0] win;

  assign win   = {hist_q, bit_in};
  assign match = bit_valid && (fill_q == FULL) && (win == pattern);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (bit_valid) begin
      hist_q <= win[PAT_W-2:0];
      // Non-overlapping mode restarts the fill so a match cannot reuse bits.
      if (match && !overlap)
        fill_q <= '0;
      else if (fill_q != FULL)
        fill_q <= fill_q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-level controller: accepts a word, serialises it MSB-first into the matcher, reports count/first/hit.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned PAT_W  = 4,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [CNT_W-1:0]  out_first,
  output logic              out_hit,
  output logic              busy
);

  localparam logic [CNT_W-1:0] NONE = CNT_W'(none_idx(WORD_W));
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);
  localparam logic [PAT_W-1:0] PAT_RST = DEF_PATTERN[PAT_W-1:0];

  state_e             state_q;
  logic [WORD_W-1:0]  word_q;
  logic [CNT_W-1:0]   idx_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   first_q;
  logic [PAT_W-1:0]   pat_q;
  logic               ovl_q;

  logic               accept;
  logic               shifting;
  logic               match;
  logic [WORD_W-1:0]  word_sh;

  assign in_ready  = (state_q == IDLE) && !cfg_we;
  assign accept    = in_valid && in_ready;
  assign shifting  = (state_q == SHIFT);
  assign word_sh   = word_q << idx_q;

  assign out_valid = (state_q == REPORT);
  assign busy      = (state_q != IDLE);
  assign out_count = count_q;
  assign out_first = first_q;
  assign out_hit   = (count_q != '0);

  seq_match_core #(.PAT_W(PAT_W)) u_match (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .bit_valid (shifting),
    .bit_in    (word_sh[WORD_W-1]),
    .pattern   (pat_q),
    .overlap   (ovl_q),
    .match     (match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      first_q <= NONE;
      pat_q   <= PAT_RST;
      ovl_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Config write wins over a word in the same cycle; in_ready is low then.
          if (cfg_we) begin
            pat_q <= cfg_pattern;
            ovl_q <= cfg_overlap;
          end else if (in_valid) begin
            word_q  <= in_word;
            idx_q   <= '0;
            count_q <= '0;
            first_q <= NONE;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          idx_q <= idx_q + 1'b1;
          if (match) begin
            count_q <= count_q + 1'b1;
            if (first_q == NONE)
              first_q <= idx_q;
          end
          if (idx_q == LAST)
            state_q <= REPORT;
        end
        REPORT: begin
          if (out_ready)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: defaults, overlap, no-match, backpressure, config gating, mid-word reset.
module tb_seq_detect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [3:0]  cfg_pattern;
  logic        cfg_overlap;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_count;
  logic [4:0]  out_first;
  logic        out_hit;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.WORD_W(16), .PAT_W(4), .CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_word     (in_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_count   (out_count),
    .out_first   (out_first),
    .out_hit     (out_hit),
    .busy        (busy)
  );

  // Present a word and hold it until accepted; returns at the first negedge after the accepting edge.
  task automatic push_word(input logic [15:0] w);
    bit done = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = w;
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if (in_ready) done = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL push_accept word=%h in_ready never rose", w);
    end
  endtask

  // Counts negedges since the accepting edge (first negedge = 1) until out_valid is seen.
  task automatic wait_result(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL result_timeout out_valid=%b required 1", out_valid);
    end
  endtask

  task automatic pop_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic write_cfg(input logic [3:0] p, input logic ovl);
    @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = p; cfg_overlap = ovl;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_count !== 5'd0)   begin errors++; $display("FAIL reset_count got %0d want 0", out_count); end
    checks++; if (out_first !== 5'd16)  begin errors++; $display("FAIL reset_first got %0d want 16", out_first); end
    checks++; if (out_hit !== 1'b0)     begin errors++; $display("FAIL reset_hit got %b want 0", out_hit); end
  endtask

  task automatic test_default_6666();
    int cyc;
    push_word(16'h6666);
    wait_result(cyc);
    checks++; if (cyc != 17)            begin errors++; $display("FAIL latency_6666 got %0d want 17", cyc); end
    checks++; if (out_count !== 5'd4)   begin errors++; $display("FAIL count_6666 got %0d want 4", out_count); end
    checks++; if (out_first !== 5'd3)   begin errors++; $display("FAIL first_6666 got %0d want 3", out_first); end
    checks++; if (out_hit !== 1'b1)     begin errors++; $display("FAIL hit_6666 got %b want 1", out_hit); end
    pop_result();
    #1;
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL drop_6666 out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_overlap_6c00();
    int cyc;
    push_word(16'h6C00);
    wait_result(cyc);
    checks++; if (out_count !== 5'd1)   begin errors++; $display("FAIL count_6c00_nonovl got %0d want 1", out_count); end
    checks++; if (out_first !== 5'd3)   begin errors++; $display("FAIL first_6c00_nonovl got %0d want 3", out_first); end
    pop_result();
    write_cfg(4'b0110, 1'b1);
    push_word(16'h6C00);
    wait_result(cyc);
    checks++; if (out_count !== 5'd2)   begin errors++; $display("FAIL count_6c00_ovl got %0d want 2", out_count); end
    checks++; if (out_first !== 5'd3)   begin errors++; $display("FAIL first_6c00_ovl got %0d want 3", out_first); end
    pop_result();
  endtask

  task automatic test_no_match();
    int cyc;
    push_word(16'hFFFF);
    wait_result(cyc);
    checks++; if (out_count !== 5'd0)   begin errors++; $display("FAIL count_ffff got %0d want 0", out_count); end
    checks++; if (out_hit !== 1'b0)     begin errors++; $display("FAIL hit_ffff got %b want 0", out_hit); end
    checks++; if (out_first !== 5'd16)  begin errors++; $display("FAIL first_ffff got %0d want 16", out_first); end
    pop_result();
  endtask

  task automatic test_backpressure();
    int cyc;
    push_word(16'h6666);
    wait_result(cyc);
    in_valid = 1'b1;
    in_word  = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_count !== 5'd4 || out_first !== 5'd3 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d valid=%b count=%0d first=%0d in_ready=%b want 1/4/3/0",
                 i, out_valid, out_count, out_first, in_ready);
      end
    end
    in_valid = 1'b0;
    pop_result();
    #1;
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL hold_no_second_word busy got %b want 0", busy); end
  endtask

  task automatic test_cfg_gating();
    int cyc;
    write_cfg(4'b0110, 1'b0);
    push_word(16'h6F00);
    repeat (3) @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = 4'b1111; cfg_overlap = 1'b0;
    @(negedge clk);
    cfg_we = 1'b0;
    wait_result(cyc);
    checks++; if (out_count !== 5'd1)   begin errors++; $display("FAIL cfg_shift_count got %0d want 1", out_count); end
    checks++; if (out_first !== 5'd3)   begin errors++; $display("FAIL cfg_shift_first got %0d want 3", out_first); end
    pop_result();
    // Config write and word offered in the same IDLE cycle.
    @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = 4'b1111; cfg_overlap = 1'b0;
    in_valid = 1'b1; in_word = 16'h6F00;
    #1;
    checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL cfg_prio_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    cfg_we = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL cfg_next_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL cfg_next_accept busy got %b want 1", busy); end
    wait_result(cyc);
    checks++; if (out_count !== 5'd1)   begin errors++; $display("FAIL cfg_new_count got %0d want 1", out_count); end
    checks++; if (out_first !== 5'd7)   begin errors++; $display("FAIL cfg_new_first got %0d want 7", out_first); end
    pop_result();
  endtask

  task automatic test_reset_mid();
    int cyc;
    push_word(16'h6666);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    push_word(16'h6666);
    wait_result(cyc);
    checks++; if (out_count !== 5'd4)   begin errors++; $display("FAIL midrst_count got %0d want 4", out_count); end
    checks++; if (out_first !== 5'd3)   begin errors++; $display("FAIL midrst_first got %0d want 3", out_first); end
    pop_result();
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_pattern = 4'b0; cfg_overlap = 1'b0;
    in_valid = 1'b0; in_word = 16'h0; out_ready = 1'b0;
    test_reset();
    test_default_6666();
    test_overlap_6c00();
    test_no_match();
    test_backpressure();
    test_cfg_gating();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
